pipe_hazard_sched: RTL and testbench
====================================

Name: pipe_hazard_sched

Overview:
- Scheduler for the decode/operand-fetch stage of the 023A core.
- Tracks in-flight instructions' side effects (TPC, IPC, flag, CS) in a scoreboard, then generates the decode-stage stop, bubble insertion and 4-cycle-instruction holds.
- Sequences interrupt entry by draining the pipeline before acknowledging.
- Sits between fetch, decode and execute; its stop output drives the decode stage's isStop.

Parameters:
- PIPE_DEPTH, 3, number of downstream stages tracked in the scoreboard (1..6).
- FOUR_CYC_HOLD, 3, extra hold cycles inserted after a 4-cycle instruction issues (1..7).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- dec_valid  input  1  decode stage holds a real instruction.
- dec_dep_tpc  input  1  decoded instruction reads TPC.
- dec_dep_ipc  input  1  decoded instruction reads IPC.
- dec_dep_flag  input  1  decoded instruction reads flag (x1/x2 channel 9 or arithmetic mode).
- dec_eff_tpc, dec_eff_ipc, dec_eff_flag, dec_eff_cs  input  1 each  decoded instruction writes TPC/IPC/flag/CS.
- dec_four_cycle  input  1  decoded instruction is a 4-cycle type.
- irq_req  input  1  level interrupt request.
- irq_num_in  input  8  interrupt number, sampled while irq_req=1 in RUN.
- stop  output  1  hold fetch and decode registers.
- bubble  output  1  issue a NOP into execute this cycle.
- irq_take  output  1  one-cycle interrupt acknowledge.
- irq_num  output  8  latched interrupt number.
- sb_busy  output  1  any scoreboard entry valid.
- stall_cnt  output  32  stall-cycle counter (HAZARD_PERF_CNT_EN only).

Behaviour:
- Reset (rst=0, asynchronous):
  - State=RUN; scoreboard cleared; hold counter=0.
  - stop=0, bubble=0, irq_take=0, irq_num=0, sb_busy=0, stall_cnt=0.
  - Reset asserted mid-stall or mid-drain aborts immediately; no irq_take is produced.
- Scoreboard: PIPE_DEPTH-entry shift register of {valid, tpc, ipc, flag, cs}. It shifts every cycle. Entry 0 loads:
  - the dec_* effect bits when an instruction issues (dec_valid & !stop);
  - zeros otherwise.
- Hazard (combinational):
  - haz = dec_valid & ((dec_dep_tpc & any tpc) | (dec_dep_ipc & any ipc) | (dec_dep_flag & any flag)).
  - "any" covers all valid entries.
  - Entry 0's effect is visible in the same cycle it becomes valid.
- States:
  - RUN:
    - haz=1 → stop=1, bubble=1; remain RUN. Re-evaluated each cycle, so the stall lasts until the producer shifts out.
    - Else, issue with dec_four_cycle=1 → load hold counter with FOUR_CYC_HOLD; go to HOLD.
    - Else, irq_req=1 and no hazard → latch irq_num_in; go to DRAIN.
    - Priority: hazard > four-cycle > irq. An issuing instruction completes before DRAIN.
  - HOLD:
    - stop=1, bubble=1; counter decrements.
    - At 1 → RUN on the next cycle. Exactly FOUR_CYC_HOLD stalled cycles.
    - irq_req is ignored in HOLD.
  - DRAIN:
    - stop=1, bubble=1 until the scoreboard is empty (sb_busy=0).
    - Then irq_take=1 for one cycle with irq_num held; go to RUN.
    - irq_req dropping during DRAIN does not cancel the acknowledge.
    - Total latency from irq_req sampled to irq_take is at most PIPE_DEPTH+1 cycles.
- Outputs stop and bubble are combinational from state and haz. irq_take and irq_num are registered.
- dec_valid=0 in RUN: no stall; a zero entry is shifted in.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments by 1 on every cycle stop=1, wrapping 0xFFFFFFFF→0. Reset to 0.
- Undefined: stall_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Reset:
  - Stimulus: rst=0 pulsed asynchronously mid-HOLD (counter=2).
  - Required: stop, bubble, sb_busy, irq_take read 0 immediately; state returns to RUN; no irq_take afterwards.
- Flag hazard:
  - Stimulus: issue an instruction with dec_eff_flag=1; next cycle present dec_dep_flag=1 (PIPE_DEPTH=3).
  - Required: stop=bubble=1 for 3 cycles, then issue on the 4th.
- No false hazard:
  - Stimulus: producer dec_eff_tpc=1, then consumer with dec_dep_ipc=1 only.
  - Required: stop=0, consumer issues next cycle.
- Four-cycle hold:
  - Stimulus: issue with dec_four_cycle=1, FOUR_CYC_HOLD=3.
  - Required: stop=1 for exactly 3 cycles, then RUN.
- Interrupt drain:
  - Stimulus: two instructions in flight; irq_req=1 with irq_num_in=0x2A.
  - Required: stop held until sb_busy=0; irq_take pulses 1 cycle with irq_num=0x2A, at most 4 cycles after the request.
- Perf counter (macro defined):
  - Stimulus: 3 hazard-stall cycles followed by 3 hold cycles.
  - Required: stall_cnt=6.
  - Preload near 0xFFFFFFFF: wraps to 0.

Source files
------------

// File: rtl/pipe_hazard_sched.sv
// Decode/operand-fetch scheduler: side-effect scoreboard, hazard stalls, 4-cycle holds, interrupt drain.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal issue; stall only while a scoreboard hazard exists
// HOLD  | fixed stall after a 4-cycle instruction issues
// DRAIN | stall until the scoreboard empties, then acknowledge the interrupt
module pipe_hazard_sched #(
    parameter int PIPE_DEPTH    = 3,
    parameter int FOUR_CYC_HOLD = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic        dec_dep_tpc,
    input  logic        dec_dep_ipc,
    input  logic        dec_dep_flag,
    input  logic        dec_eff_tpc,
    input  logic        dec_eff_ipc,
    input  logic        dec_eff_flag,
    input  logic        dec_eff_cs,
    input  logic        dec_four_cycle,
    input  logic        irq_req,
    input  logic [7:0]  irq_num_in,
    output logic        stop,
    output logic        bubble,
    output logic        irq_take,
    output logic [7:0]  irq_num,
    output logic        sb_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

    typedef struct packed {
        logic valid;
        logic tpc;
        logic ipc;
        logic flag;
        logic cs;
    } sb_entry_t;

    sb_entry_t  sb [PIPE_DEPTH];
    state_t     state;
    logic [2:0] hold_cnt;

    logic any_tpc, any_ipc, any_flag, any_cs_unused;
    logic haz, issue;

    always_comb begin
        sb_busy       = 1'b0;
        any_tpc       = 1'b0;
        any_ipc       = 1'b0;
        any_flag      = 1'b0;
        any_cs_unused = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            sb_busy       = sb_busy | sb[i].valid;
            any_tpc       = any_tpc | (sb[i].valid & sb[i].tpc);
            any_ipc       = any_ipc | (sb[i].valid & sb[i].ipc);
            any_flag      = any_flag | (sb[i].valid & sb[i].flag);
            any_cs_unused = any_cs_unused | (sb[i].valid & sb[i].cs);
        end
    end

    assign haz = dec_valid & ((dec_dep_tpc & any_tpc) |
                              (dec_dep_ipc & any_ipc) |
                              (dec_dep_flag & any_flag));

    always_comb begin
        stop = 1'b1;
        if (state == RUN) stop = haz;
    end

    assign bubble = stop;
    assign issue  = dec_valid & ~stop;

    // Entry 0 takes the issuing instruction's effects; stalled or empty cycles shift in zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) sb[i] <= '0;
        end else begin
            for (int i = PIPE_DEPTH - 1; i >= 1; i--) sb[i] <= sb[i-1];
            if (issue) sb[0] <= '{valid: 1'b1, tpc: dec_eff_tpc, ipc: dec_eff_ipc,
                                  flag: dec_eff_flag, cs: dec_eff_cs};
            else       sb[0] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            hold_cnt <= 3'd0;
            irq_take <= 1'b0;
            irq_num  <= 8'd0;
        end else begin
            irq_take <= 1'b0;
            case (state)
                RUN: begin
                    if (!haz) begin
                        if (issue && dec_four_cycle) begin
                            hold_cnt <= 3'(FOUR_CYC_HOLD);
                            state    <= HOLD;
                        end else if (irq_req) begin
                            irq_num <= irq_num_in;
                            state   <= DRAIN;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - 3'd1;
                    if (hold_cnt == 3'd1) state <= RUN;
                end
                DRAIN: begin
                    // Once requested, the acknowledge is committed even if irq_req drops.
                    if (!sb_busy) begin
                        irq_take <= 1'b1;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      stall_cnt_q <= 32'd0;
        else if (stop) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed self-checking bench for pipe_hazard_sched (PIPE_DEPTH=3, FOUR_CYC_HOLD=3).
module tb_pipe_hazard_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_dep_tpc, dec_dep_ipc, dec_dep_flag;
    logic        dec_eff_tpc, dec_eff_ipc, dec_eff_flag, dec_eff_cs;
    logic        dec_four_cycle, irq_req;
    logic [7:0]  irq_num_in;
    logic        stop, bubble, irq_take, sb_busy;
    logic [7:0]  irq_num;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_sched #(.PIPE_DEPTH(3), .FOUR_CYC_HOLD(3)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_dep_tpc(dec_dep_tpc), .dec_dep_ipc(dec_dep_ipc),
        .dec_dep_flag(dec_dep_flag), .dec_eff_tpc(dec_eff_tpc), .dec_eff_ipc(dec_eff_ipc),
        .dec_eff_flag(dec_eff_flag), .dec_eff_cs(dec_eff_cs), .dec_four_cycle(dec_four_cycle),
        .irq_req(irq_req), .irq_num_in(irq_num_in),
        .stop(stop), .bubble(bubble), .irq_take(irq_take), .irq_num(irq_num),
        .sb_busy(sb_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_inputs;
        dec_valid = 0; dec_dep_tpc = 0; dec_dep_ipc = 0; dec_dep_flag = 0;
        dec_eff_tpc = 0; dec_eff_ipc = 0; dec_eff_flag = 0; dec_eff_cs = 0;
        dec_four_cycle = 0; irq_req = 0; irq_num_in = 8'h00;
    endtask

    task idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    task test_reset;
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop got %b want 0", stop); end
        n_checks++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b want 0", bubble); end
        n_checks++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL reset_irq_take got %b want 0", irq_take); end
        n_checks++; if (irq_num !== 8'h00) begin n_fail++; $display("FAIL reset_irq_num got %h want 00", irq_num); end
        n_checks++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sb_busy got %b want 0", sb_busy); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        tick();
        rst = 1'b1;
        tick();
        // Enter HOLD, then reset asynchronously with the counter at 2.
        dec_valid = 1; dec_four_cycle = 1;
        @(negedge clk);
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL rst_pre_issue_stop got %b want 0", stop); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL rst_hold_stop got %b want 1", stop); end
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL rst_async_stop got %b want 0", stop); end
        n_checks++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL rst_async_bubble got %b want 0", bubble); end
        n_checks++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_sb_busy got %b want 0", sb_busy); end
        n_checks++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL rst_async_irq_take got %b want 0", irq_take); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (stop !== 1'b0 || irq_take !== 1'b0) begin
                n_fail++; $display("FAIL rst_after_run cycle %0d stop=%b irq_take=%b want 0 0", i, stop, irq_take);
            end
            tick();
        end
    endtask

    task test_flag_hazard;
        int stalls;
        stalls = 0;
        dec_valid = 1; dec_eff_flag = 1;
        tick();
        dec_eff_flag = 0; dec_dep_flag = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stop !== 1'b1) break;
            n_checks++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL flag_haz_bubble got %b want 1", bubble); end
            stalls++;
            tick();
        end
        n_checks++; if (stalls != 3) begin n_fail++; $display("FAIL flag_haz_stall_cycles got %0d want 3", stalls); end
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL flag_haz_release_stop got %b want 0", stop); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (sb_busy !== 1'b1) begin n_fail++; $display("FAIL flag_haz_consumer_issued got %b want 1", sb_busy); end
        idle(4);
        @(negedge clk);
        n_checks++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL flag_haz_drained got %b want 0", sb_busy); end
        tick();
    endtask

    task test_no_false_hazard;
        dec_valid = 1; dec_eff_tpc = 1;
        tick();
        dec_eff_tpc = 0; dec_dep_ipc = 1;
        @(negedge clk);
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL no_false_haz_stop got %b want 0", stop); end
        n_checks++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL no_false_haz_bubble got %b want 0", bubble); end
        tick();
        // The TPC producer now sits in entry 1; a TPC reader must stall.
        dec_dep_ipc = 0; dec_dep_tpc = 1;
        @(negedge clk);
        n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL tpc_haz_entry1_stop got %b want 1", stop); end
        idle(4);
    endtask

    task test_four_cycle;
        int holds;
        holds = 0;
        dec_valid = 1; dec_four_cycle = 1;
        @(negedge clk);
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL four_cyc_issue_stop got %b want 0", stop); end
        tick();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stop !== 1'b1) break;
            holds++;
            tick();
        end
        n_checks++; if (holds != 3) begin n_fail++; $display("FAIL four_cyc_hold_cycles got %0d want 3", holds); end
        idle(4);
    endtask

    task test_irq_drain;
        int lat;
        bit seen;
        lat = 0; seen = 0;
        dec_valid = 1; dec_eff_ipc = 1;
        tick();
        dec_eff_ipc = 0; dec_eff_flag = 1;
        irq_req = 1; irq_num_in = 8'h2A;
        tick();
        clear_inputs();
        irq_num_in = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (irq_take === 1'b1) begin seen = 1; break; end
            n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL drain_stop lat %0d got %b want 1", lat, stop); end
            tick();
            lat++;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL drain_irq_take_timeout got 0 want 1"); end
        n_checks++; if (lat > 4) begin n_fail++; $display("FAIL drain_latency got %0d want <=4", lat); end
        n_checks++; if (irq_num !== 8'h2A) begin n_fail++; $display("FAIL drain_irq_num got %h want 2a", irq_num); end
        n_checks++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL drain_sb_busy got %b want 0", sb_busy); end
        tick();
        @(negedge clk);
        n_checks++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL drain_take_one_cycle got %b want 0", irq_take); end
        n_checks++; if (stop !== 1'b0) begin n_fail++; $display("FAIL drain_back_to_run got %b want 0", stop); end
        idle(3);
    endtask

    task test_priority;
        int holds;
        bit seen;
        holds = 0; seen = 0;
        dec_valid = 1; dec_four_cycle = 1;
        irq_req = 1; irq_num_in = 8'h11;
        tick();
        dec_valid = 0; dec_four_cycle = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stop !== 1'b1) break;
            n_checks++; if (irq_take !== 1'b0) begin n_fail++; $display("FAIL prio_take_in_hold got %b want 0", irq_take); end
            holds++;
            tick();
        end
        n_checks++; if (holds != 3) begin n_fail++; $display("FAIL prio_hold_cycles got %0d want 3", holds); end
        tick();
        irq_req = 0; irq_num_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (irq_take === 1'b1) begin seen = 1; break; end
            tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL prio_irq_take_timeout got 0 want 1"); end
        n_checks++; if (irq_num !== 8'h11) begin n_fail++; $display("FAIL prio_irq_num got %h want 11", irq_num); end
        idle(3);
    endtask

    task test_perf;
        logic [31:0] base;
        @(negedge clk);
        base = stall_cnt;
        tick();
        // Three hazard stalls followed by a three-cycle hold.
        dec_valid = 1; dec_eff_flag = 1;
        tick();
        dec_eff_flag = 0; dec_dep_flag = 1; dec_four_cycle = 1;
        repeat (4) tick();
        clear_inputs();
        repeat (5) tick();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        n_checks++; if (stall_cnt - base !== 32'd6) begin
            n_fail++; $display("FAIL perf_stall_cnt got %0d want 6", stall_cnt - base);
        end
`else
        n_checks++; if (stall_cnt !== 32'd0 || base !== 32'd0) begin
            n_fail++; $display("FAIL perf_stall_cnt_tied got %0d want 0", stall_cnt);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_flag_hazard();
        test_no_false_hazard();
        test_four_cycle();
        test_irq_drain();
        test_priority();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
